i2c_byte_controller: RTL
========================

Name: i2c_byte_controller

Overview:
- Byte-level I2C master sequencer. It generates SCL, START, STOP and repeated-START conditions.
- Each transaction serialises one byte MSB-first onto SDA (write) or collects one byte from SDA (read), plus the ACK/NACK bit.
- Sits between the I2C command logic and the open-drain pad drivers. It owns the bus timing and the 8-bit serial datapath that the command logic loads and reads back.

Parameters:
- CLK_DIV, 250: CLK cycles per quarter SCL period. Legal range 2..65535; a value below 2 is illegal.
- DIV_W, 16: width of the quarter-period counter.

Ports:
- CLK  in  1  system clock; all state changes on posedge.
- RESET  in  1  asynchronous, active-high reset.
- Go  in  1  start a transaction; sampled only when Busy=0.
- Rw  in  1  0=write TxByte, 1=read into RxByte; captured with Go.
- Restart  in  1  when the bus is held, issue a repeated START first; captured with Go.
- StopAfter  in  1  issue STOP after the ACK bit; when 0, hold the bus. On reads it also selects NACK (1) or ACK (0).
- TxByte  in  8  write data; captured with Go.
- RxByte  out  8  read data; valid from Done until the next Go.
- Busy  out  1  transaction in progress.
- Done  out  1  one-cycle completion pulse.
- AckError  out  1  write: slave NACKed. Valid with Done, held until next Go.
- SCL  out  1  SCL drive (1=release, 0=pull low).
- SDAOut  out  1  SDA drive (1=release, 0=pull low).
- SDAIn  in  1  synchronised SDA pad level.
- SCLIn  in  1  synchronised SCL pad level; used only with CLOCK_STRETCH_EN.

Behaviour:
- Reset (async), takes effect immediately and without a clock:
  - SCL=1, SDAOut=1, Busy=0, Done=0, AckError=0, RxByte=0x00.
  - State=IDLE, divider=0, no STOP emitted.
- Quarter tick: divider counts 0..CLK_DIV-1 and ticks at CLK_DIV-1. It is cleared on Go acceptance. Each phase (Q0..Q3) lasts CLK_DIV cycles.
- States: IDLE, START, DATA, ACK, STOP, HOLD.
- IDLE:
  - SCL=1, SDAOut=1.
  - Go → START (Restart ignored).
- HOLD:
  - SCL=0, SDA unchanged.
  - Go with Restart=1 → START.
  - Go with Restart=0 → DATA.
- START: Q0 SDA=1 SCL=0→1 (from HOLD) or 1; Q1 SDA=1 SCL=1; Q2 SDA=0 SCL=1; Q3 SDA=0 SCL=0 → DATA.
- DATA, 8 bits with a bit counter 7 down to 0:
  - SCL=1 in Q1, Q2 only.
  - SDAOut updates at Q0 entry: write = shifter MSB; read = 1.
  - SDAIn is sampled at the end of Q1 and shifted into the LSB on reads.
  - Bit 0 Q3 end → ACK.
- ACK:
  - SDAOut = 1 for a write, StopAfter for a read.
  - Write: AckError = SDAIn sampled at Q1 end.
  - At Q3 end: StopAfter=1 → STOP; otherwise → HOLD with Done.
- STOP: Q0 SDA=0 SCL=0; Q1 SDA=0 SCL=1; Q2 SDA=1 SCL=1; Q3 SDA=1 SCL=1. Q3 end → IDLE with Done.
- Handshake:
  - Go sampled while Busy=0 is accepted.
  - Busy rises the next cycle and falls in the cycle Done pulses.
  - Go while Busy=1 is ignored and not queued.
- Latency, Go at edge 0, Done high during the cycle after edge N:
  - START+byte+STOP: N = 44*CLK_DIV.
  - byte from HOLD, no restart, no STOP: N = 36*CLK_DIV.
- Simultaneous events: Go in the Done cycle is accepted, since Busy=0 that cycle.
- RxByte is loaded on the ACK-phase entry of a read. It is never partially updated on a visible boundary.

Optional Feature:
- Macro: I2C_CLOCK_STRETCH_EN.
- Defined: when the controller releases SCL (Q1 entry), the divider freezes while SCLIn=0. The count resumes once SCLIn=1, so a slave may stretch indefinitely.
- Undefined: SCLIn is ignored and timing is purely CLK_DIV-driven.

Decomposition:
- Package i2c_pkg holds:
  - state enum (IDLE, START, DATA, ACK, STOP, HOLD);
  - phase constants Q0..Q3;
  - I2C_ACK=1'b0 and I2C_NACK=1'b1;
  - default CLK_DIV.
- Sub-module i2c_quarter_timer: divider, tick output, clear input, and freeze input (used by stretch).
- The serial datapath is an 8-bit shift register inside the controller, controlled by load/shift strobes from the FSM.

Test Plan:
- CLK_DIV=4, Go Rw=0 TxByte=0xA5 StopAfter=1, SDAIn=0 at ACK:
  - SDA bits at SCL rise are 1,0,1,0,0,1,0,1.
  - AckError=0; Done during cycle 177; final SCL=1 SDAOut=1.
- Same stimulus but SDAIn=1 during ACK → AckError=1; STOP still issued; Done at cycle 177.
- Go Rw=1 StopAfter=1 with slave presenting 0x3C → RxByte=0x3C; SDAOut=1 in the ACK bit (NACK).
- Write 0x12 with StopAfter=0 → state HOLD with SCL=0 and Busy=0. Then Go Restart=1 Rw=1 → SDA falls while SCL=1 before the first data bit.
- Assert RESET at mid-bit 4 → SCL=1, SDAOut=1, Busy=0 in the same cycle, without waiting for an edge. Go after release → normal START.
- Pulse Go every cycle during a write → only the first is accepted; exactly one Done pulse. With I2C_CLOCK_STRETCH_EN, hold SCLIn=0 for 20 cycles at bit 3 → Done is delayed by exactly 20 cycles.

Source files
------------

// File: rtl/i2c_byte_controller_pkg.sv
// Shared state encoding, phase constants and defaults for the I2C byte controller.
package i2c_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, ACK, STOP, HOLD} stateT;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam int CLK_DIV_DEFAULT = 250;

endpackage

// File: rtl/i2c_byte_controller_if.sv
// Command-side handshake plus open-drain pad signals of the I2C byte controller.
interface i2c_byte_if;
  logic       Go;
  logic       Rw;
  logic       Restart;
  logic       StopAfter;
  logic [7:0] TxByte;
  logic [7:0] RxByte;
  logic       Busy;
  logic       Done;
  logic       AckError;
  logic       SCL;
  logic       SDAOut;
  logic       SDAIn;
  logic       SCLIn;

  modport slave (
    input  Go, Rw, Restart, StopAfter, TxByte, SDAIn, SCLIn,
    output RxByte, Busy, Done, AckError, SCL, SDAOut
  );

  modport master (
    output Go, Rw, Restart, StopAfter, TxByte, SDAIn, SCLIn,
    input  RxByte, Busy, Done, AckError, SCL, SDAOut
  );
endinterface

// File: rtl/i2c_byte_controller_quarter_timer.sv
// Quarter-SCL-period divider: counts 0..CLK_DIV-1, ticks on the last count.
// CLK_DIV must be at least 2; freeze holds the count (used for clock stretching).
module i2c_quarter_timer #(
  parameter int CLK_DIV = 250,
  parameter int DIV_W   = 16
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear,
  input  logic freeze,
  output logic tick
);
  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] count;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)        count <= '0;
    else if (clear)   count <= '0;
    else if (!freeze) count <= (count == LAST) ? '0 : count + DIV_W'(1);
  end

  assign tick = (count == LAST) && !freeze;
endmodule

// File: rtl/i2c_byte_controller.sv
// Byte-level I2C master sequencer: START / 8 data bits / ACK / STOP or bus hold.
// Optional macro I2C_CLOCK_STRETCH_EN freezes the Q1 divider while a slave holds SCL low.
module i2c_byte_controller
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT,
  parameter int DIV_W   = 16
) (
  input logic       CLK,
  input logic       RESET,
  i2c_byte_if.slave bus
);
  stateT       state, stateNext;
  logic [1:0]  phase, phaseNext;
  logic [2:0]  bitCnt, bitCntNext;
  logic [7:0]  shifter, shiftD, rxQ, rxD;
  logic        rwQ, stopQ, fromHold, rwD, stopD, fromHoldD;
  logic        sclQ, sdaQ, sclD, sdaD;
  logic        doneQ, doneD, ackErrQ, ackErrD;
  logic        loadStrb, shiftStrb, goAcc, tick, freeze;

  assign goAcc = bus.Go && (state == IDLE || state == HOLD);

`ifdef I2C_CLOCK_STRETCH_EN
  assign freeze = sclQ && (phase == Q1) && !bus.SCLIn && bus.Busy;
`else
  logic unusedSclIn;
  assign unusedSclIn = bus.SCLIn;
  assign freeze      = 1'b0;
`endif

  i2c_quarter_timer #(.CLK_DIV(CLK_DIV), .DIV_W(DIV_W)) uTimer (
    .CLK(CLK), .RESET(RESET), .clear(goAcc), .freeze(freeze), .tick(tick)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      phase    <= Q0;
      bitCnt   <= 3'd7;
      rwQ      <= 1'b0;
      stopQ    <= 1'b0;
      fromHold <= 1'b0;
      sclQ     <= 1'b1;
      sdaQ     <= 1'b1;
      doneQ    <= 1'b0;
      ackErrQ  <= 1'b0;
      rxQ      <= 8'h00;
    end else begin
      state    <= stateNext;
      phase    <= phaseNext;
      bitCnt   <= bitCntNext;
      rwQ      <= rwD;
      stopQ    <= stopD;
      fromHold <= fromHoldD;
      sclQ     <= sclD;
      sdaQ     <= sdaD;
      doneQ    <= doneD;
      ackErrQ  <= ackErrD;
      rxQ      <= rxD;
    end
  end

  always_ff @(posedge CLK) shifter <= shiftD;

  always_comb begin
    stateNext  = state;
    phaseNext  = phase;
    bitCntNext = bitCnt;
    rwD        = rwQ;
    stopD      = stopQ;
    fromHoldD  = fromHold;
    doneD      = 1'b0;
    ackErrD    = ackErrQ;
    rxD        = rxQ;
    loadStrb   = 1'b0;
    shiftStrb  = 1'b0;
    sclD       = 1'b1;
    sdaD       = sdaQ;

    case (state)
      IDLE, HOLD: begin
        if (goAcc) begin
          stateNext  = (state == HOLD && !bus.Restart) ? DATA : START;
          phaseNext  = Q0;
          bitCntNext = 3'd7;
          rwD        = bus.Rw;
          stopD      = bus.StopAfter;
          fromHoldD  = (state == HOLD);
          ackErrD    = 1'b0;
          loadStrb   = 1'b1;
        end
      end
      default: begin
        if (tick) begin
          phaseNext = phase + 2'd1;
          case (state)
            START: if (phase == Q3) stateNext = DATA;
            DATA: begin
              // One shift per bit at Q1 end: samples SDA for reads and exposes the next MSB for writes.
              if (phase == Q1) shiftStrb = 1'b1;
              if (phase == Q3) begin
                if (bitCnt == 3'd0) begin
                  stateNext = ACK;
                  if (rwQ) rxD = shifter;
                end else begin
                  bitCntNext = bitCnt - 3'd1;
                end
              end
            end
            ACK: begin
              if (phase == Q1 && !rwQ) ackErrD = bus.SDAIn;
              if (phase == Q3) begin
                if (stopQ) begin
                  stateNext = STOP;
                end else begin
                  stateNext = HOLD;
                  doneD     = 1'b1;
                end
              end
            end
            STOP: begin
              if (phase == Q3) begin
                stateNext = IDLE;
                doneD     = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    endcase

    shiftD = loadStrb  ? (bus.Rw ? 8'hFF : bus.TxByte) :
             shiftStrb ? {shifter[6:0], bus.SDAIn} : shifter;

    // Pad drive is decoded from the next state so it changes in lockstep with the phase.
    case (stateNext)
      IDLE: begin sclD = 1'b1; sdaD = 1'b1; end
      HOLD: sclD = 1'b0;
      START: begin
        sclD = (phaseNext == Q0) ? !fromHoldD : (phaseNext != Q3);
        sdaD = !phaseNext[1];
      end
      DATA: begin
        sclD = (phaseNext == Q1) || (phaseNext == Q2);
        if (phaseNext == Q0) sdaD = rwD ? 1'b1 : shiftD[7];
      end
      ACK: begin
        sclD = (phaseNext == Q1) || (phaseNext == Q2);
        sdaD = rwD ? (stopD ? I2C_NACK : I2C_ACK) : 1'b1;
      end
      STOP: begin
        sclD = (phaseNext != Q0);
        sdaD = phaseNext[1];
      end
      default: ;
    endcase
  end

  assign bus.SCL      = sclQ;
  assign bus.SDAOut   = sdaQ;
  assign bus.Busy     = (state != IDLE) && (state != HOLD);
  assign bus.Done     = doneQ;
  assign bus.AckError = ackErrQ;
  assign bus.RxByte   = rxQ;
endmodule
